mem_responder: RTL



---
 rtl/mem_defs.sv | 14 +
 rtl/mem_array.sv | 26 ++
 rtl/mem_responder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mem_defs.sv
// Shared definitions for the memory responder: word width, byte-offset width
// and the responder state encoding.
package mem_defs;

  localparam int WORD_W     = 32;
  localparam int BYTE_OFF_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_array.sv
// Word-wide storage with synchronous write and registered read.
// Contents are never reset.
module mem_array
  import mem_defs::*;
#(
  parameter int    DEPTH_WORDS = 256,
  parameter string INIT_FILE   = "",
  localparam int   AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Single access port: a write commits the word, a read captures it.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one outstanding word request, WAIT_CYCLES wait
// states, then a read-data or write-acknowledge response held until taken.
// Optional feature macro: MEM_ALIGN_CHECK_EN adds resp_err and suppresses
// accesses whose byte address is not word aligned.
module mem_responder
  import mem_defs::*;
#(
  parameter int    DEPTH_WORDS = 256,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
`ifdef MEM_ALIGN_CHECK_EN
  output logic              resp_err,
`endif
  output logic              busy
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  // Captured request (data only, never reset)
  logic              we_q;
  logic [AW-1:0]     idx_q;
  logic [1:0]        off_q;
  logic [WORD_W-1:0] wdata_q;

  // Response qualifiers latched on the access edge
  logic rd_sel_q;
  logic err_q;

  // Access-edge selection: with zero wait states the access happens on the
  // accepting edge, so the live request is used instead of the capture.
  logic              acc_go;
  logic              acc_we;
  logic [AW-1:0]     acc_idx;
  logic [1:0]        acc_off;
  logic [WORD_W-1:0] acc_wdata;
  logic              acc_err;
  logic              mem_we;
  logic              mem_re;
  logic [WORD_W-1:0] mem_rdata;

  logic unused_addr_bits;

  // Choose live or captured request and decide whether this edge performs the access.
  always_comb begin
    acc_go    = ((state == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                ((state == WAIT) && (cnt == 4'd0));
    acc_we    = (state == IDLE) ? req_we : we_q;
    acc_idx   = (state == IDLE) ? req_addr[BYTE_OFF_W +: AW] : idx_q;
    acc_off   = (state == IDLE) ? req_addr[BYTE_OFF_W-1:0] : off_q;
    acc_wdata = (state == IDLE) ? req_wdata : wdata_q;
`ifdef MEM_ALIGN_CHECK_EN
    acc_err   = (acc_off != 2'd0);
`else
    acc_err   = 1'b0;
`endif
    // A write is never committed while reset is held.
    mem_we    = acc_go && acc_we && !acc_err && !rst;
    mem_re    = acc_go && !acc_we && !acc_err;
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign unused_addr_bits = ^req_addr[31:BYTE_OFF_W+AW];
`else
  assign unused_addr_bits = ^{req_addr[31:BYTE_OFF_W+AW], acc_off, off_q};
`endif

  mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_FILE   (INIT_FILE)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (acc_idx),
    .wdata (acc_wdata),
    .rdata (mem_rdata)
  );

  // State, wait counter and response qualifiers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      rd_sel_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (acc_go) begin
        rd_sel_q <= !acc_we && !acc_err;
        err_q    <= acc_err;
      end
    end
  end

  // Capture the accepted request for use on the later access edge.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && req_valid) begin
      we_q    <= req_we;
      idx_q   <= req_addr[BYTE_OFF_W +: AW];
      off_q   <= req_addr[BYTE_OFF_W-1:0];
      wdata_q <= req_wdata;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (WAIT_CYCLES > 0) begin
            state_nxt = WAIT;
            cnt_nxt   = WAIT_INIT;
          end else begin
            state_nxt = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read data is only visible while a read response is pending.
  assign resp_rdata = ((state == RESP) && rd_sel_q) ? mem_rdata : '0;
`ifdef MEM_ALIGN_CHECK_EN
  assign resp_err   = (state == RESP) && err_q;
`endif

endmodule
